add_residue_guard: RTL and testbench

- Fault-tolerant sequencer that sits directly upstream and downstream of the 16-bit carry-select adder.
- Accepts an operand transaction, drives the operands into the external combinational adder, and samples its {carry, sum} result.
- Checks the result with a mod-3 residue code and re-evaluates the adder on mismatch, up to a bounded retry count.
- Delivers the result with an uncorrectable-error flag over a valid/ready handshake and keeps error statistics.

---
 rtl/add_residue_guard.sv | 177 +++++++++++++++++
 tb/tb_add_residue_guard.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_residue_guard.sv
// add_residue_guard: wraps an external combinational adder, checks each
// {carry, sum} result with a mod-3 residue code, re-evaluates on mismatch
// up to MAX_RETRY times, and reports uncorrectable results with statistics.
module add_residue_guard #(
  parameter int WIDTH     = 16,
  parameter int MAX_RETRY = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_res,
  output logic                 out_err,
  output logic [2:0]           out_retries,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0]           RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE     = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     add_a_q, add_a_d;
  logic [WIDTH-1:0]     add_b_q, add_b_d;
  logic                 add_cin_q, add_cin_d;
  logic [WIDTH:0]       res_q, res_d;
  logic                 err_q, err_d;
  logic [2:0]           retries_q, retries_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sticky_q, sticky_d;

  logic [1:0]           res_expected;
  logic [1:0]           res_actual;
  logic                 uncorrectable;

  // Residue mod 3: since 4 == 1 (mod 3), even bit positions weigh 1 and
  // odd positions weigh 2; accumulate the weights, then reduce.
  function automatic logic [1:0] mod3(input logic [WIDTH:0] v);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'd0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (v[i]) acc = acc + (i[0] ? 8'd2 : 8'd1);
    end
    m = acc % 8'd3;
    return m[1:0];
  endfunction

  // Residue of (ra + rb + cin); the raw sum never exceeds 5.
  function automatic logic [1:0] add_mod3(input logic [1:0] ra,
                                          input logic [1:0] rb,
                                          input logic       c);
    logic [2:0] s;
    s = {1'b0, ra} + {1'b0, rb} + {2'b00, c};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Residues are taken from registered operands and the registered result,
  // so the check never depends on adder settling within the CHECK cycle.
  always_comb begin
    res_expected = add_mod3(mod3({1'b0, add_a_q}), mod3({1'b0, add_b_q}), add_cin_q);
    res_actual   = mod3(res_q);
  end

  // Sequencer: accept, evaluate, check with bounded retry, hold until taken.
  always_comb begin
    state_d       = state_q;
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    add_cin_d     = add_cin_q;
    res_d         = res_q;
    err_d         = err_q;
    retries_d     = retries_q;
    uncorrectable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_cin_d = in_cin;
          retries_d = 3'd0;
          err_d     = 1'b0;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        res_d   = {add_cout, add_sum};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (res_expected == res_actual) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (retries_q < RETRY_LIMIT) begin
          retries_d = retries_q + 3'd1;
          state_d   = S_EVAL;
        end else begin
          err_d         = 1'b1;
          uncorrectable = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Error statistics; a clear in the same cycle as a new error wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    if (clr_err) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (uncorrectable) begin
      sticky_d = 1'b1;
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
      retries_q <= 3'd0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      res_q     <= res_d;
      err_q     <= err_d;
      retries_q <= retries_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_cin     = add_cin_q;
  assign out_res     = res_q;
  assign out_err     = err_q;
  assign out_retries = retries_q;
  assign err_count   = err_cnt_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_add_residue_guard.sv
// Directed bench for add_residue_guard: a behavioural adder with fault
// injection feeds two guards (8-bit and 2-bit error counters).
module tb_add_residue_guard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic        trans_fault = 1'b0;
  logic        stuck0 = 1'b0;

  logic        in_ready, in_ready2;
  logic [15:0] add_a, add_b, add_sum, add_a2, add_b2, add_sum2;
  logic        add_cin, add_cout, add_cin2, add_cout2;
  logic        out_valid, out_err, err_sticky, out_valid2, out_err2, err_sticky2;
  logic [16:0] out_res, out_res2;
  logic [2:0]  out_retries, out_retries2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [16:0] adder(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic tf, input logic sf);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    if (tf) r[15:0] = r[15:0] + 16'd1;
    if (sf) r[0] = 1'b1;
    return r;
  endfunction

  assign {add_cout,  add_sum}  = adder(add_a,  add_b,  add_cin,  trans_fault, stuck0);
  assign {add_cout2, add_sum2} = adder(add_a2, add_b2, add_cin2, trans_fault, stuck0);

  add_residue_guard #(.WIDTH(16), .MAX_RETRY(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_err(out_err), .out_retries(out_retries),
    .err_count(err_count), .err_sticky(err_sticky), .clr_err(clr_err));

  add_residue_guard #(.WIDTH(16), .MAX_RETRY(2), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
    .add_sum(add_sum2), .add_cout(add_cout2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_res(out_res2),
    .out_err(out_err2), .out_retries(out_retries2),
    .err_count(err_count2), .err_sticky(err_sticky2), .clr_err(clr_err));

  // Present one transaction; returns just after the accept edge.
  task automatic do_accept(input logic [15:0] a, input logic [15:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid; cyc uses the
  // numbering where the accept edge starts cycle 0 (fault-free => 3).
  task automatic wait_valid(input int start, output int cyc);
    int n;
    n = start;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    cyc = out_valid ? n + 1 : -1;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s_handshake out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    nchk++;
    if (add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0 || out_res !== 17'd0 ||
        out_retries !== 3'd0 || err_count !== 8'd0 || out_valid !== 1'b0 ||
        out_err !== 1'b0 || err_sticky !== 1'b0) begin
      nerr++;
      $display("FAIL reset_values a=%h b=%h res=%h rt=%0d cnt=%0d v=%b e=%b s=%b required all 0",
               add_a, add_b, out_res, out_retries, err_count, out_valid, out_err, err_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_fault_free;
    int cyc;
    do_accept(16'h1234, 16'h4321, 1'b1);
    nchk++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL busy_in_ready got %b required 0", in_ready);
    end
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 3 || out_res !== 17'h05556 || out_err !== 1'b0 || out_retries !== 3'd0 ||
        err_count !== 8'd0) begin
      nerr++;
      $display("FAIL fault_free cyc=%0d res=%h err=%b rt=%0d cnt=%0d required 3/05556/0/0/0",
               cyc, out_res, out_err, out_retries, err_count);
    end
    handshake("fault_free");
  endtask

  task automatic test_overflow;
    int cyc;
    do_accept(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 3 || out_res !== 17'h10000 || out_err !== 1'b0) begin
      nerr++;
      $display("FAIL overflow_1 cyc=%0d res=%h err=%b required 3/10000/0", cyc, out_res, out_err);
    end
    handshake("overflow_1");
    do_accept(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 3 || out_res !== 17'h1FFFF || out_err !== 1'b0) begin
      nerr++;
      $display("FAIL overflow_2 cyc=%0d res=%h err=%b required 3/1FFFF/0", cyc, out_res, out_err);
    end
    handshake("overflow_2");
  endtask

  task automatic test_transient;
    int cyc;
    trans_fault = 1'b1;
    do_accept(16'h0010, 16'h0020, 1'b0);
    @(posedge clk); #1;
    trans_fault = 1'b0;
    wait_valid(1, cyc);
    nchk++;
    if (cyc != 5 || out_res !== 17'h00030 || out_err !== 1'b0 || out_retries !== 3'd1 ||
        err_count !== 8'd0) begin
      nerr++;
      $display("FAIL transient cyc=%0d res=%h err=%b rt=%0d cnt=%0d required 5/00030/0/1/0",
               cyc, out_res, out_err, out_retries, err_count);
    end
    handshake("transient");
  endtask

  task automatic test_permanent;
    int cyc;
    stuck0 = 1'b1;
    do_accept(16'h0002, 16'h0002, 1'b0);
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 7 || out_res !== 17'h00005 || out_err !== 1'b1 || out_retries !== 3'd2 ||
        err_count !== 8'd1 || err_sticky !== 1'b1 || err_count2 !== 2'd1) begin
      nerr++;
      $display("FAIL permanent cyc=%0d res=%h err=%b rt=%0d cnt=%0d st=%b required 7/00005/1/2/1/1",
               cyc, out_res, out_err, out_retries, err_count, err_sticky);
    end
    stuck0 = 1'b0;
    handshake("permanent");
  endtask

  task automatic test_backpressure;
    int cyc;
    int bad;
    do_accept(16'h00A5, 16'h0F0F, 1'b0);
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 3 || out_res !== 17'h00FB4) begin
      nerr++;
      $display("FAIL bp_result cyc=%0d res=%h required 3/00FB4", cyc, out_res);
    end
    in_a = 16'hDEAD; in_b = 16'hBEEF; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== 17'h00FB4 ||
          out_err !== 1'b0 || out_retries !== 3'd0 || add_a !== 16'h00A5) bad++;
    end
    nchk++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk); #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_a !== 16'h00A5) begin
      nerr++;
      $display("FAIL bp_idle in_ready=%b out_valid=%b add_a=%h required 1/0/00a5",
               in_ready, out_valid, add_a);
    end
  endtask

  task automatic test_saturation;
    int cyc;
    stuck0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_accept(16'h0002, 16'h0002, 1'b0);
      wait_valid(0, cyc);
      handshake("sat_txn");
    end
    nchk++;
    if (err_count2 !== 2'd3 || err_count !== 8'd4 || err_sticky2 !== 1'b1) begin
      nerr++;
      $display("FAIL saturation cnt2=%0d cnt=%0d st2=%b required 3/4/1", err_count2, err_count, err_sticky2);
    end
    // Fifth uncorrectable result: clear lands on the edge that would count it.
    do_accept(16'h0002, 16'h0002, 1'b0);
    repeat (5) @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    nchk++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || err_count !== 8'd0 || err_count2 !== 2'd0 ||
        err_sticky !== 1'b0 || err_sticky2 !== 1'b0) begin
      nerr++;
      $display("FAIL clr_wins v=%b e=%b cnt=%0d cnt2=%0d st=%b st2=%b required 1/1/0/0/0/0",
               out_valid, out_err, err_count, err_count2, err_sticky, err_sticky2);
    end
    stuck0 = 1'b0;
    handshake("clr");
  endtask

  task automatic test_reset_mid;
    int cyc;
    do_accept(16'h0100, 16'h0200, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    nchk++;
    if (add_a !== 16'd0 || add_b !== 16'd0 || out_res !== 17'd0 || out_valid !== 1'b0 ||
        err_count !== 8'd0 || out_retries !== 3'd0) begin
      nerr++;
      $display("FAIL reset_mid a=%h b=%h res=%h v=%b cnt=%0d required all 0",
               add_a, add_b, out_res, out_valid, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    do_accept(16'h0100, 16'h0200, 1'b1);
    wait_valid(0, cyc);
    nchk++;
    if (cyc != 3 || out_res !== 17'h00301 || out_err !== 1'b0) begin
      nerr++;
      $display("FAIL after_reset cyc=%0d res=%h err=%b required 3/00301/0", cyc, out_res, out_err);
    end
    handshake("after_reset");
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_overflow();
    test_transient();
    test_permanent();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
